// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helpers for the fifo_ctrl slice.
//   SKID_DEPTH  - entries in the output skid buffer
//   skid_occ_t  - skid occupancy (0..SKID_DEPTH)
//   ptr_diff    - modulo pointer subtraction; callers truncate to their
//                 pointer width (ALEN+1 bits including the wrap bit)
package fifo_pkg;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned PTR_MAX_W  = 32;

  typedef logic [1:0] skid_occ_t;

  function automatic logic [PTR_MAX_W-1:0] ptr_diff(
    input logic [PTR_MAX_W-1:0] a,
    input logic [PTR_MAX_W-1:0] b
  );
    return a - b;
  endfunction

endpackage

// File: rtl/fifo_skid.sv
// fifo_skid: 2-entry in-order buffer in front of the consumer.
//   clk, rst   - clock, async active-high reset
//   push       - write push_data this edge (caller guarantees space)
//   push_data  - data to store
//   pop        - consumer takes the head this edge (ignored when empty)
//   occ        - current occupancy
//   out_valid  - head is valid (occ != 0)
//   out_data   - head entry
module fifo_skid
  import fifo_pkg::*;
#(
  parameter int unsigned DLEN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [DLEN-1:0] push_data,
  input  logic            pop,
  output skid_occ_t       occ,
  output logic            out_valid,
  output logic [DLEN-1:0] out_data
);

  localparam skid_occ_t OCC_FULL = skid_occ_t'(SKID_DEPTH);

  logic [DLEN-1:0] head_q, head_d;
  logic [DLEN-1:0] tail_q, tail_d;
  skid_occ_t       occ_q, occ_d;
  logic            pop_ok;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    pop_ok = pop && (occ_q != '0);
    unique case ({push, pop_ok})
      2'b10: begin
        if (occ_q == '0) head_d = push_data;
        else             tail_d = push_data;
        occ_d = occ_q + skid_occ_t'(1);
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - skid_occ_t'(1);
      end
      2'b11: begin
        // Occupancy unchanged; new data lands behind whatever remains.
        if (occ_q == skid_occ_t'(1)) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign out_valid = (occ_q != '0);
  assign out_data  = head_q;

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop_ok && occ_q == OCC_FULL));

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FWFT FIFO controller driving an external
// two-port RAM (1-cycle registered read). Owns pointers, occupancy and
// flags; a 2-entry skid buffer hides the RAM read latency.
//   clk, rst                 - clock, async active-high reset
//   s_valid/s_ready/s_data   - producer side
//   m_valid/m_ready/m_data   - consumer side (head of FIFO)
//   o_count                  - total occupancy (RAM + in-flight + skid)
//   o_ram_wen/waddr/wdata    - RAM write port
//   o_ram_ren/raddr          - RAM read address (ren marks an issued read)
//   i_ram_rdata              - RAM read data, one cycle after raddr
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DLEN = 8,
  parameter int unsigned ALEN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DLEN-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DLEN-1:0] m_data,
  output logic [ALEN+1:0] o_count,
  output logic            o_ram_wen,
  output logic [ALEN-1:0] o_ram_waddr,
  output logic [DLEN-1:0] o_ram_wdata,
  output logic            o_ram_ren,
  output logic [ALEN-1:0] o_ram_raddr,
  input  logic [DLEN-1:0] i_ram_rdata
);

  localparam int unsigned   PW        = ALEN + 1;
  localparam int unsigned   CW        = ALEN + 2;
  localparam logic [PW-1:0] RAM_DEPTH = PW'(1 << ALEN);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;

  logic [PW-1:0] ram_cnt, ram_cnt_d;
  logic          full, accept, pop, ren;
  logic [2:0]    lookahead;
  skid_occ_t     skid_occ, skid_occ_d;
  logic          skid_valid;
  logic [DLEN-1:0] skid_data;

  always_comb begin
    // Occupancy from registered pointers only: a word written this cycle
    // is not readable until the next, avoiding RAM read-during-write.
    ram_cnt = PW'(ptr_diff(PTR_MAX_W'(wptr_q), PTR_MAX_W'(rptr_q)));
    full    = (ram_cnt == RAM_DEPTH);
    s_ready = !full && !rst;
    accept  = s_valid && s_ready;
    pop     = skid_valid && m_ready;

    // Issue only if the returning word is guaranteed a skid slot.
    lookahead = 3'(skid_occ) + 3'(inflight_q) - 3'(pop);
    ren       = (ram_cnt != '0) && (lookahead < 3'd2);

    wptr_d     = wptr_q + PW'(accept);
    rptr_d     = rptr_q + PW'(ren);
    inflight_d = ren;

    skid_occ_d = skid_occ + skid_occ_t'(inflight_q) - skid_occ_t'(pop);
    ram_cnt_d  = PW'(ptr_diff(PTR_MAX_W'(wptr_d), PTR_MAX_W'(rptr_d)));
    count_d    = CW'(ram_cnt_d) + CW'(inflight_d) + CW'(skid_occ_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
    end
  end

  fifo_skid #(
    .DLEN(DLEN)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data(i_ram_rdata),
    .pop      (pop),
    .occ      (skid_occ),
    .out_valid(skid_valid),
    .out_data (skid_data)
  );

  assign m_valid     = skid_valid;
  assign m_data      = skid_data;
  assign o_count     = count_q;
  assign o_ram_wen   = accept;
  assign o_ram_waddr = wptr_q[ALEN-1:0];
  assign o_ram_wdata = s_data;
  assign o_ram_ren   = ren;
  assign o_ram_raddr = rptr_q[ALEN-1:0];

  skid_budget: assert property (@(posedge clk) disable iff (rst)
    (3'(skid_occ) + 3'(inflight_q)) <= 3'd2);

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Synchronous FIFO controller with first-word-fall-through output. It sits between a ready/valid producer and consumer and drives an external two-port RAM. That RAM has one write port, and its read port has a registered output with one-cycle latency that samples its address every cycle. The controller owns the pointers, occupancy and full/empty flags. A 2-entry output skid buffer hides the RAM read latency and sustains 1 transfer/cycle under backpressure.

Parameters:
DLEN, 8, data width in bits
ALEN, 4, RAM address width; RAM depth = 2**ALEN; total FIFO capacity = 2**ALEN + 2

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
s_valid  in  1  producer data valid
s_ready  out  1  controller can accept a write
s_data  in  DLEN  write data
m_valid  out  1  output data valid
m_ready  in  1  consumer accepts output
m_data  out  DLEN  head-of-FIFO data
o_count  out  ALEN+2  total occupancy (RAM + in-flight + skid)
o_ram_wen  out  1  RAM write enable
o_ram_waddr  out  ALEN  RAM write address
o_ram_wdata  out  DLEN  RAM write data
o_ram_ren  out  1  read issued this cycle (informational; RAM reads every cycle)
o_ram_raddr  out  ALEN  RAM read address
i_ram_rdata  in  DLEN  RAM read data, valid 1 cycle after raddr

Behaviour:
- Reset (rst=1, async):
  - wptr, rptr (ALEN+1 bits, MSB = wrap bit) = 0; inflight = 0; skid empty.
  - m_valid=0, m_data=0, o_count=0, o_ram_wen=0, o_ram_ren=0.
  - s_ready forced 0 while rst is high.
- Write:
  - Accepted when s_valid && s_ready.
  - o_ram_wen = accept (combinational); o_ram_waddr = wptr[ALEN-1:0]; o_ram_wdata = s_data.
  - wptr increments at the edge.
- ram_cnt = wptr - rptr, ALEN+1 bits, modulo arithmetic.
- full: ram_cnt == 2**ALEN; s_ready = !full && !rst. A write is never accepted into a full RAM, even if a read is issued the same cycle (registered-full semantics).
- Read issue (prefetch):
  - o_ram_ren = (ram_cnt != 0) && (skid_occ + inflight - pop) < 2, where pop = m_valid && m_ready.
  - ram_cnt uses registered pointers only, so an entry written in cycle N is readable from cycle N+1. This avoids the RAM read-during-write returning old data.
  - o_ram_raddr = rptr[ALEN-1:0] (combinational). On issue, rptr increments and inflight is set for the next cycle.
- Return: when inflight=1, i_ram_rdata is pushed into the skid at that edge.
- Invariant: skid_occ + inflight <= 2 at all times; violation is an assertion failure.
- Skid:
  - 2-entry FIFO; head drives m_data; m_valid = skid_occ != 0.
  - Simultaneous push and pop: occupancy unchanged, order preserved.
- Latency: write accepted in cycle 0 to an empty FIFO → read issued cycle 1 → rdata cycle 2 → m_valid=1 in cycle 3.
- Throughput: 1 write + 1 read per cycle sustained.
- Wrap-around: address bits wrap 2**ALEN-1 → 0; the wrap bit distinguishes full from empty.
- o_count:
  - Registered; updated every edge as ram_cnt + inflight + skid_occ, using next-state values.
  - Range 0..2**ALEN+2.
- Reset mid-operation:
  - Contents discarded; inflight cleared, so the RAM's returning data is ignored.
  - The RAM's own stale output is never captured.
- m_valid/m_data hold stable while m_ready=0 (AXI-style rules). s_ready does not depend on s_valid.

Decomposition:
- Package fifo_pkg:
  - function ptr_diff (ALEN+1-bit modulo subtract)
  - localparam SKID_DEPTH = 2
  - typedef for the skid occupancy width
- Sub-module fifo_skid: 2-entry ready/valid buffer with push/pop/occupancy outputs. The controller holds only pointer, inflight and count logic.

Test Plan:
1. Reset: assert rst mid-clock → m_valid=0, s_ready=0, o_count=0 immediately; deassert → s_ready=1 next cycle.
2. Single write 0xA5 at cycle 0, m_ready=1 → o_ram_ren=1, raddr=0 in cycle 1; m_valid=1 with m_data=0xA5 in cycle 3; o_count back to 0 in cycle 4.
3. Fill (ALEN=2), m_ready=0, write 1..7 back-to-back → 6 accepted; s_ready=0 once ram_cnt=4; o_count=6. Then m_ready=1 → outputs 1..6 in order, one per cycle.
4. Streaming 20 words with s_valid=m_ready=1 → after 3-cycle latency, one output per cycle in order; waddr/raddr wrap 3→0 four times.
5. Random s_valid/m_ready (10k cycles, ALEN=2) vs scoreboard → no loss/duplication; skid_occ+inflight ≤ 2; o_count matches model every cycle.
6. Assert rst in the cycle after a read issue (inflight=1), with rdata 0x5A arriving → after release m_valid=0, o_count=0, 0x5A never appears on m_data.
